// File: rtl/ps2_event_fifo.sv
// PS/2 Set-2 byte stream to key-event converter: prefix decoding, typematic
// suppression against the held key, and a small show-ahead event FIFO.
//
// state    | meaning
// ---------+--------------------------------------------
// IDLE     | no prefix pending
// GOT_E0   | E0 seen, next code is an extended make
// GOT_F0   | F0 seen, next code is a plain break
// GOT_E0F0 | E0 F0 seen, next code is an extended break
module ps2_event_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag,
   input  logic [7:0] scancode,
   input  logic       rd_en,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       key_down,
   output logic [7:0] held_code,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

   state_t            state, state_nxt;
   logic              gen, gen_ext, gen_brk;
   logic              discard, is_e0, is_f0;
   logic              hv, hext;
   logic [7:0]        hcode;
   logic              match, push, do_pop, full, accept;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic [9:0]        mem [FIFO_DEPTH];
   logic [9:0]        head;

   always_comb begin
      discard = 1'b0;
      case (scancode)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: discard = 1'b1;
         default: discard = 1'b0;
      endcase
   end

   assign is_e0 = (scancode == 8'hE0);
   assign is_f0 = (scancode == 8'hF0);

   always_comb begin
      state_nxt = state;
      gen       = 1'b0;
      gen_ext   = 1'b0;
      gen_brk   = 1'b0;
      if (flag) begin
         if (discard) begin
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (is_e0)      state_nxt = GOT_E0;
                  else if (is_f0) state_nxt = GOT_F0;
                  else            gen = 1'b1;
               end
               GOT_E0: begin
                  if (is_f0)      state_nxt = GOT_E0F0;
                  else if (is_e0) state_nxt = GOT_E0;
                  else begin
                     gen       = 1'b1;
                     gen_ext   = 1'b1;
                     state_nxt = IDLE;
                  end
               end
               GOT_F0: begin
                  if (is_f0)      state_nxt = GOT_F0;
                  else if (is_e0) state_nxt = GOT_E0;
                  else begin
                     gen       = 1'b1;
                     gen_brk   = 1'b1;
                     state_nxt = IDLE;
                  end
               end
               GOT_E0F0: begin
                  state_nxt = IDLE;
                  if (!is_e0 && !is_f0) begin
                     gen     = 1'b1;
                     gen_ext = 1'b1;
                     gen_brk = 1'b1;
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Repeated makes of the held key are typematic and never reach the FIFO.
   assign match  = hv && (hext == gen_ext) && (hcode == scancode);
   assign push   = gen && (gen_brk || !match);
   assign full   = (count == FULL_CNT);
   assign do_pop = rd_en && (count != '0);
   assign accept = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hv    <= 1'b0;
         hext  <= 1'b0;
         hcode <= 8'h00;
      end else if (gen) begin
         if (!gen_brk && !match) begin
            hv    <= 1'b1;
            hext  <= gen_ext;
            hcode <= scancode;
         end else if (gen_brk && match) begin
            hv    <= 1'b0;
            hext  <= 1'b0;
            hcode <= 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= {gen_ext, gen_brk, scancode};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (accept && !do_pop)      count <= count + 1'b1;
         else if (!accept && do_pop) count <= count - 1'b1;
         if (push && !accept) overflow <= 1'b1;
      end
   end

   assign head      = mem[rd_ptr];
   assign ev_valid  = (count != '0);
   assign ev_ext    = head[9];
   assign ev_break  = head[8];
   assign ev_code   = head[7:0];
   assign key_down  = hv;
   assign held_code = hcode;

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Directed self-checking bench for ps2_event_fifo: per-cycle vector table
// plus hand-written reset and discard-inside-prefix sequences.
module tb_ps2_event_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flag = 1'b0;
   logic [7:0] scancode = 8'h00;
   logic       rd_en = 1'b0;
   logic       ev_valid, ev_ext, ev_break, key_down, overflow;
   logic [7:0] ev_code, held_code;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ps2_event_fifo #(.FIFO_DEPTH(4), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset), .flag(flag), .scancode(scancode), .rd_en(rd_en),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
      .key_down(key_down), .held_code(held_code), .overflow(overflow)
   );

   typedef struct {
      bit       rst;
      bit       flg;
      bit [7:0] sc;
      bit       rd;
      bit       v;
      bit [7:0] code;
      bit       ext;
      bit       brk;
      bit       kd;
      bit [7:0] held;
      bit       ov;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input bit flg, input bit [7:0] sc, input bit rd,
                      input bit v, input bit [7:0] code, input bit ext, input bit brk,
                      input bit kd, input bit [7:0] held, input bit ov);
      vec_t t;
      t.rst = rst; t.flg = flg; t.sc = sc; t.rd = rd; t.v = v; t.code = code;
      t.ext = ext; t.brk = brk; t.kd = kd; t.held = held; t.ov = ov;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit flg, input bit [7:0] sc, input bit rd);
      @(negedge clk);
      flag = flg; scancode = sc; rd_en = rd;
      @(posedge clk);
      #1;
      flag = 1'b0; rd_en = 1'b0;
   endtask

   task automatic chk_head(input string name, input bit [7:0] code, input bit ext, input bit brk);
      chk({name, ".valid"}, 32'(ev_valid), 32'd1);
      chk({name, ".head"}, {22'd0, ev_ext, ev_break, ev_code}, {22'd0, ext, brk, code});
   endtask

   initial begin
      // {rst, flag, sc, rd} -> {valid, code, ext, brk, key_down, held, overflow}
      add(0,1,8'h1C,0, 1,8'h1C,0,0, 1,8'h1C,0);
      add(0,1,8'hF0,0, 1,8'h1C,0,0, 1,8'h1C,0);
      add(0,1,8'h1C,0, 1,8'h1C,0,0, 0,8'h00,0);
      add(0,0,8'h00,1, 1,8'h1C,0,1, 0,8'h00,0);
      add(0,0,8'h00,1, 0,8'h00,0,0, 0,8'h00,0);
      add(0,1,8'hE0,0, 0,8'h00,0,0, 0,8'h00,0);
      add(0,1,8'h75,0, 1,8'h75,1,0, 1,8'h75,0);
      add(0,1,8'hE0,0, 1,8'h75,1,0, 1,8'h75,0);
      add(0,1,8'hF0,0, 1,8'h75,1,0, 1,8'h75,0);
      add(0,1,8'h75,0, 1,8'h75,1,0, 0,8'h00,0);
      add(0,1,8'h75,0, 1,8'h75,1,0, 1,8'h75,0);
      add(0,0,8'h00,1, 1,8'h75,1,1, 1,8'h75,0);
      add(0,0,8'h00,1, 1,8'h75,0,0, 1,8'h75,0);
      add(0,0,8'h00,1, 0,8'h00,0,0, 1,8'h75,0);
      // typematic repeats
      add(0,1,8'h1C,0, 1,8'h1C,0,0, 1,8'h1C,0);
      for (int i = 0; i < 4; i++) add(0,1,8'h1C,0, 1,8'h1C,0,0, 1,8'h1C,0);
      add(0,1,8'hF0,0, 1,8'h1C,0,0, 1,8'h1C,0);
      add(0,1,8'h1C,0, 1,8'h1C,0,0, 0,8'h00,0);
      add(0,0,8'h00,1, 1,8'h1C,0,1, 0,8'h00,0);
      add(0,0,8'h00,1, 0,8'h00,0,0, 0,8'h00,0);
      // overflow with depth 4
      add(0,1,8'h15,0, 1,8'h15,0,0, 1,8'h15,0);
      add(0,1,8'h1D,0, 1,8'h15,0,0, 1,8'h1D,0);
      add(0,1,8'h24,0, 1,8'h15,0,0, 1,8'h24,0);
      add(0,1,8'h2D,0, 1,8'h15,0,0, 1,8'h2D,0);
      add(0,1,8'h2C,0, 1,8'h15,0,0, 1,8'h2C,1);
      add(0,0,8'h00,1, 1,8'h1D,0,0, 1,8'h2C,1);
      add(0,0,8'h00,1, 1,8'h24,0,0, 1,8'h2C,1);
      add(0,0,8'h00,1, 1,8'h2D,0,0, 1,8'h2C,1);
      add(0,0,8'h00,1, 0,8'h00,0,0, 1,8'h2C,1);
      // reset, fill, then pop-and-push while full across the pointer wrap
      add(1,1,8'h16,0, 1,8'h16,0,0, 1,8'h16,0);
      add(0,1,8'h1E,0, 1,8'h16,0,0, 1,8'h1E,0);
      add(0,1,8'h26,0, 1,8'h16,0,0, 1,8'h26,0);
      add(0,1,8'h25,0, 1,8'h16,0,0, 1,8'h25,0);
      add(0,1,8'h2E,1, 1,8'h1E,0,0, 1,8'h2E,0);
      add(0,1,8'h36,1, 1,8'h26,0,0, 1,8'h36,0);
      add(0,1,8'h3D,1, 1,8'h25,0,0, 1,8'h3D,0);
      add(0,0,8'h00,1, 1,8'h2E,0,0, 1,8'h3D,0);
      add(0,0,8'h00,1, 1,8'h36,0,0, 1,8'h3D,0);
      add(0,0,8'h00,1, 1,8'h3D,0,0, 1,8'h3D,0);
      add(0,0,8'h00,1, 0,8'h00,0,0, 1,8'h3D,0);
      // push into empty FIFO with rd_en high
      add(0,1,8'h3E,1, 1,8'h3E,0,0, 1,8'h3E,0);
      add(0,0,8'h00,1, 0,8'h00,0,0, 1,8'h3E,0);
      // F0 then E0 abandons the break
      add(0,1,8'hF0,0, 0,8'h00,0,0, 1,8'h3E,0);
      add(0,1,8'hE0,0, 0,8'h00,0,0, 1,8'h3E,0);
      add(0,1,8'h3E,0, 1,8'h3E,1,0, 1,8'h3E,0);
      add(0,0,8'h00,1, 0,8'h00,0,0, 1,8'h3E,0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset.valid", 32'(ev_valid), 32'd0);
      chk("reset.key_down", 32'(key_down), 32'd0);
      chk("reset.held", 32'(held_code), 32'd0);
      chk("reset.overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         if (vecs[i].rst) begin
            reset = 1'b0;
            #2;
            reset = 1'b1;
         end
         flag = vecs[i].flg; scancode = vecs[i].sc; rd_en = vecs[i].rd;
         @(posedge clk);
         #1;
         flag = 1'b0; rd_en = 1'b0;
         chk($sformatf("v%0d.valid", i), 32'(ev_valid), 32'(vecs[i].v));
         chk($sformatf("v%0d.key_down", i), 32'(key_down), 32'(vecs[i].kd));
         chk($sformatf("v%0d.held", i), 32'(held_code), 32'(vecs[i].held));
         chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].ov));
         if (vecs[i].v)
            chk($sformatf("v%0d.head", i), {22'd0, ev_ext, ev_break, ev_code},
                {22'd0, vecs[i].ext, vecs[i].brk, vecs[i].code});
      end

      // reset in the middle of an E0 prefix, asserted asynchronously mid-cycle
      drive(1, 8'h24, 0);
      drive(1, 8'hE0, 0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst.valid", 32'(ev_valid), 32'd0);
      chk("async_rst.key_down", 32'(key_down), 32'd0);
      chk("async_rst.held", 32'(held_code), 32'd0);
      #1;
      reset = 1'b1;
      drive(1, 8'h1C, 0);
      chk_head("after_rst", 8'h1C, 0, 0);
      drive(0, 8'h00, 1);
      chk("after_rst.single", 32'(ev_valid), 32'd0);

      // discard bytes inside prefixes return the FSM to IDLE with no event
      drive(1, 8'hE0, 0);
      drive(1, 8'hAA, 0);
      chk("disc_e0.none", 32'(ev_valid), 32'd0);
      drive(1, 8'h21, 0);
      chk_head("disc_e0", 8'h21, 0, 0);
      drive(0, 8'h00, 1);
      drive(1, 8'hF0, 0);
      drive(1, 8'hFA, 0);
      chk("disc_f0.none", 32'(ev_valid), 32'd0);
      drive(1, 8'h22, 0);
      chk_head("disc_f0", 8'h22, 0, 0);
      drive(0, 8'h00, 1);
      drive(1, 8'hE0, 0);
      drive(1, 8'hF0, 0);
      drive(1, 8'h00, 0);
      chk("disc_e0f0.none", 32'(ev_valid), 32'd0);
      drive(1, 8'h23, 0);
      chk_head("disc_e0f0", 8'h23, 0, 0);
      chk("disc.held", 32'(held_code), 32'h23);
      drive(0, 8'h00, 1);
      chk("disc.empty", 32'(ev_valid), 32'd0);
      chk("disc.overflow", 32'(overflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_event_fifo.md
# ps2_event_fifo

Sits between `kbd_protocol` and `scancode_decoder`, in the `clkdiv4` domain. Turns the raw PS/2 Set-2 byte stream (`scancode` plus a one-cycle `flag` strobe) into discrete key events: {extended, break, code}. Drops protocol and status bytes and suppresses typematic auto-repeat. Buffers events in a small show-ahead FIFO so the consumer can pop them at its own pace.

## Interface
- FIFO_DEPTH, 4, number of event entries; power of two, at least 2
- ADDR_W, 2, log2(FIFO_DEPTH)
- clk  input  1  pixel-domain clock (`clkdiv4`)
- reset  input  1  asynchronous, active-low; clears all state
- flag  input  1  byte-valid strobe from `kbd_protocol`; every cycle it is high counts as one byte
- scancode  input  8  received byte; sampled only when `flag`=1
- rd_en  input  1  pop the head entry; ignored when the FIFO is empty
- ev_valid  output  1  FIFO not empty
- ev_code  output  8  head entry key code
- ev_ext  output  1  head entry was E0-prefixed
- ev_break  output  1  head entry is a release (F0-prefixed)
- key_down  output  1  a key is currently held (tracked make)
- held_code  output  8  code of the held key; 8'h00 when none is held
- overflow  output  1  sticky; an event was dropped because the FIFO was full

## Operation
- **Prefix FSM** states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. The FSM only advances on cycles where `flag`=1.
- **Discard set** {00, AA, EE, FA, FC, FD, FE, FF}: in any state the byte is dropped, the FSM goes to IDLE, and no event is produced.
- **IDLE**:
  - E0 goes to GOT_E0.
  - F0 goes to GOT_F0.
  - Any other byte emits a make event with ext=0.
- **GOT_E0**:
  - F0 goes to GOT_E0F0.
  - E0 stays in GOT_E0.
  - Any other byte emits a make event with ext=1 and returns to IDLE.
- **GOT_F0**:
  - F0 stays in GOT_F0.
  - E0 goes to GOT_E0, abandoning the break.
  - Any other byte emits a break event with ext=0 and returns to IDLE.
- **GOT_E0F0**:
  - E0 or F0 returns to IDLE with no event.
  - Any other byte emits a break event with ext=1 and returns to IDLE.
- **Held tracker**: a register {hv, hext, hcode}. A key matches when both code and ext match.
  - Make matching the held key while hv=1: suppressed, no push.
  - Make not matching: pushed; the tracker loads the new key with hv=1.
  - Break matching the held key: pushed; the tracker clears to hv=0, hcode=00.
  - Break not matching: pushed; the tracker is unchanged.
  - The tracker updates even if the push is dropped for overflow.
- **FIFO**:
  - Entry is 10 bits {ext, break, code}; read and write pointers are ADDR_W bits wide, plus a count of ADDR_W+1 bits.
  - Push when full and `rd_en`=0: the event is dropped and `overflow` sets. `overflow` clears only on reset.
  - Push when full and `rd_en`=1: the pop frees a slot, the push is accepted, and the count is unchanged.
  - Push when empty with `rd_en`=1: the push is accepted and `rd_en` is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- **Outputs**:
  - `ev_*` show the head entry combinationally from the read pointer (show-ahead).
  - `ev_code`/`ev_ext`/`ev_break` are don't-care while `ev_valid`=0.
  - `key_down`=hv and `held_code`=hcode, both registered.

## Timing
- **Reset** (reset=0, asynchronous) forces:
  - FSM to IDLE;
  - pointers and count to 0, so `ev_valid`=0;
  - `overflow`=0, `key_down`=0, `held_code`=00.
  - Reset asserted mid-sequence (for example after E0) discards the partial prefix.
- **Latency**:
  - `flag` at edge N with an event-producing byte: the entry is written at edge N. `ev_valid` and the head outputs reflect it after edge N (visible in cycle N+1) if the FIFO was empty.
  - `key_down`/`held_code` update at the same edge N.
- **Pop**: `rd_en`=1 with `ev_valid`=1 advances the head at that edge. The next entry is visible in the following cycle.
- **Consecutive strobes**: `flag` high on back-to-back cycles processes one byte per cycle, so at most one push per cycle.

## Test plan
- Bytes 1C, F0 1C (rd_en=0) -> entries {0,0,1C}, {0,1,1C}; key_down goes 1 then 0; held_code 1C then 00.
- E0 75, E0 F0 75 -> entries {1,0,75}, {1,1,75}; make 75 with ext=0 sent afterwards is a new key and is pushed.
- Typematic: 1C ×5 then F0 1C -> only 2 entries; no push for the 4 repeats.
- Overflow: 5 distinct makes (15, 1D, 24, 2D, 2C) with rd_en=0 and depth 4 -> first 4 stored, `overflow`=1, `held_code`=2C; then pop all 4 in order -> `ev_valid`=0.
- Full plus simultaneous pop-and-push -> count stays 4, no overflow, order preserved across pointer wrap.
- Bytes E0 then reset pulse then 1C -> single entry {0,0,1C}; bytes AA, FA, 00 inside a prefix sequence -> no entries, FSM back to IDLE.
